// File: rtl/fpu_decoder.sv
// Registered decoder for single-precision RISC-V OP-FP instructions: one-hot
// unit enables, register addresses and register-file strobes, one cycle after sampling.
module fpu_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic        Fadd_en,
  output logic        Fsub_en,
  output logic        Fmul_en,
  output logic        Fdiv_en,
  output logic        Fsqrt_en,
  output logic        Fmax_en,
  output logic        Fmin_en,
  output logic        Feq_en,
  output logic        Flt_en,
  output logic        Fleq_en,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rd_en,
  output logic        wr_en
);

  localparam logic [6:0] OP_FP = 7'b1010011;

  // Enable vector bit positions
  localparam int EN_ADD  = 0;
  localparam int EN_SUB  = 1;
  localparam int EN_MUL  = 2;
  localparam int EN_DIV  = 3;
  localparam int EN_SQRT = 4;
  localparam int EN_MAX  = 5;
  localparam int EN_MIN  = 6;
  localparam int EN_EQ   = 7;
  localparam int EN_LT   = 8;
  localparam int EN_LE   = 9;

  logic [6:0] w_funct7;
  logic [4:0] w_rs2f;
  logic [4:0] w_rs1f;
  logic [2:0] w_funct3;
  logic [4:0] w_rdf;
  logic [6:0] w_opcode;

  logic [9:0] w_en;
  logic       w_valid;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  logic [9:0] r_en;
  logic [4:0] r_rs1;
  logic [4:0] r_rs2;
  logic [4:0] r_rd;
  logic       r_rd_en;
  logic       r_wr_en;

  assign w_funct7 = instruction[31:25];
  assign w_rs2f   = instruction[24:20];
  assign w_rs1f   = instruction[19:15];
  assign w_funct3 = instruction[14:12];
  assign w_rdf    = instruction[11:7];
  assign w_opcode = instruction[6:0];

  // Combinational decode of the unit enable; anything unrecognised leaves it all-zero
  always_comb begin
    w_en = 10'b0;
    if (w_opcode == OP_FP) begin
      case (w_funct7)
        7'b0000000: w_en[EN_ADD] = 1'b1;
        7'b0000100: w_en[EN_SUB] = 1'b1;
        7'b0001000: w_en[EN_MUL] = 1'b1;
        7'b0001100: w_en[EN_DIV] = 1'b1;
        7'b0101100: begin
          if (w_rs2f == 5'd0) begin
            w_en[EN_SQRT] = 1'b1;
          end else begin
            w_en = 10'b0;
          end
        end
        7'b0010100: begin
          case (w_funct3)
            3'b000:  w_en[EN_MIN] = 1'b1;
            3'b001:  w_en[EN_MAX] = 1'b1;
            default: w_en = 10'b0;
          endcase
        end
        7'b1010000: begin
          case (w_funct3)
            3'b010:  w_en[EN_EQ] = 1'b1;
            3'b001:  w_en[EN_LT] = 1'b1;
            3'b000:  w_en[EN_LE] = 1'b1;
            default: w_en = 10'b0;
          endcase
        end
        default: w_en = 10'b0;
      endcase
    end else begin
      w_en = 10'b0;
    end
  end

  // Register addresses are zeroed on invalid decode; FSQRT has no second operand
  always_comb begin
    w_valid = |w_en;
    w_rs1   = 5'd0;
    w_rs2   = 5'd0;
    w_rd    = 5'd0;
    if (w_valid) begin
      w_rs1 = w_rs1f;
      w_rd  = w_rdf;
      w_rs2 = w_en[EN_SQRT] ? 5'd0 : w_rs2f;
    end else begin
      w_rs1 = 5'd0;
      w_rs2 = 5'd0;
      w_rd  = 5'd0;
    end
  end

  // Output register with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en    <= 10'b0;
      r_rs1   <= 5'd0;
      r_rs2   <= 5'd0;
      r_rd    <= 5'd0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_en    <= w_en;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_rd    <= w_rd;
      r_rd_en <= w_valid;
      r_wr_en <= w_valid;
    end
  end

  assign Fadd_en  = r_en[EN_ADD];
  assign Fsub_en  = r_en[EN_SUB];
  assign Fmul_en  = r_en[EN_MUL];
  assign Fdiv_en  = r_en[EN_DIV];
  assign Fsqrt_en = r_en[EN_SQRT];
  assign Fmax_en  = r_en[EN_MAX];
  assign Fmin_en  = r_en[EN_MIN];
  assign Feq_en   = r_en[EN_EQ];
  assign Flt_en   = r_en[EN_LT];
  assign Fleq_en  = r_en[EN_LE];
  assign rs1      = r_rs1;
  assign rs2      = r_rs2;
  assign rd       = r_rd;
  assign rd_en    = r_rd_en;
  assign wr_en    = r_wr_en;

endmodule

// File: tb/tb_fpu_decoder.sv
// Directed bench for fpu_decoder: expected outputs are queued when an instruction
// is driven and compared one cycle later when the registered result appears.
module tb_fpu_decoder;

  localparam logic [6:0] OP = 7'b1010011;

  localparam logic [9:0] E_ADD  = 10'b1000000000;
  localparam logic [9:0] E_SUB  = 10'b0100000000;
  localparam logic [9:0] E_MUL  = 10'b0010000000;
  localparam logic [9:0] E_DIV  = 10'b0001000000;
  localparam logic [9:0] E_SQRT = 10'b0000100000;
  localparam logic [9:0] E_MAX  = 10'b0000010000;
  localparam logic [9:0] E_MIN  = 10'b0000001000;
  localparam logic [9:0] E_EQ   = 10'b0000000100;
  localparam logic [9:0] E_LT   = 10'b0000000010;
  localparam logic [9:0] E_LE   = 10'b0000000001;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        Fadd_en, Fsub_en, Fmul_en, Fdiv_en, Fsqrt_en;
  logic        Fmax_en, Fmin_en, Feq_en, Flt_en, Fleq_en;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_en, wr_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [26:0] exp;
  } exp_t;

  exp_t exp_q[$];

  fpu_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .Fadd_en     (Fadd_en),
    .Fsub_en     (Fsub_en),
    .Fmul_en     (Fmul_en),
    .Fdiv_en     (Fdiv_en),
    .Fsqrt_en    (Fsqrt_en),
    .Fmax_en     (Fmax_en),
    .Fmin_en     (Fmin_en),
    .Feq_en      (Feq_en),
    .Flt_en      (Flt_en),
    .Fleq_en     (Fleq_en),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .rd_en       (rd_en),
    .wr_en       (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] observed();
    return {Fadd_en, Fsub_en, Fmul_en, Fdiv_en, Fsqrt_en, Fmax_en, Fmin_en,
            Feq_en, Flt_en, Fleq_en, rs1, rs2, rd, rd_en, wr_en};
  endfunction

  function automatic logic [26:0] mk(input logic [9:0] en, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] d,
                                     input logic v);
    return {en, a, b, d, v, v};
  endfunction

  function automatic logic [31:0] ins(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] d, input logic [6:0] op);
    return {f7, r2, r1, f3, d, op};
  endfunction

  task automatic check_now(input string tag, input logic [26:0] exp);
    logic [26:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one instruction at the falling edge, compare after the next rising edge
  task automatic step(input string tag, input logic [31:0] i, input logic [26:0] exp);
    exp_t e;
    @(negedge clk);
    instruction = i;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_now(e.tag, e.exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    instruction = ins(7'b0000000, 5'd10, 5'd17, 3'b000, 5'd15, OP);
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_hold", 27'd0);

    @(negedge clk);
    rst = 1'b1;
    instruction = 32'h0000_0000;
    @(posedge clk);
    #1;
    check_now("release_zero", 27'd0);

    step("fadd",  ins(7'b0000000, 5'd10, 5'd17, 3'b000, 5'd15, OP), mk(E_ADD,  5'd17, 5'd10, 5'd15, 1'b1));
    step("fsub",  ins(7'b0000100, 5'd8,  5'd22, 3'b000, 5'd5,  OP), mk(E_SUB,  5'd22, 5'd8,  5'd5,  1'b1));
    step("fmul",  ins(7'b0001000, 5'd12, 5'd17, 3'b001, 5'd27, OP), mk(E_MUL,  5'd17, 5'd12, 5'd27, 1'b1));
    step("fdiv",  ins(7'b0001100, 5'd3,  5'd4,  3'b111, 5'd6,  OP), mk(E_DIV,  5'd4,  5'd3,  5'd6,  1'b1));
    step("fsqrt", ins(7'b0101100, 5'd0,  5'd23, 3'b001, 5'd25, OP), mk(E_SQRT, 5'd23, 5'd0,  5'd25, 1'b1));
    step("fsqrt_rs2_nz", ins(7'b0101100, 5'd1, 5'd23, 3'b001, 5'd25, OP), 27'd0);
    step("fmax",  ins(7'b0010100, 5'd13, 5'd21, 3'b001, 5'd19, OP), mk(E_MAX,  5'd21, 5'd13, 5'd19, 1'b1));
    step("fmin",  ins(7'b0010100, 5'd1,  5'd2,  3'b000, 5'd3,  OP), mk(E_MIN,  5'd2,  5'd1,  5'd3,  1'b1));
    step("minmax_bad_f3", ins(7'b0010100, 5'd1, 5'd2, 3'b010, 5'd3, OP), 27'd0);
    step("feq",   ins(7'b1010000, 5'd27, 5'd19, 3'b010, 5'd8,  OP), mk(E_EQ,   5'd19, 5'd27, 5'd8,  1'b1));
    step("flt",   ins(7'b1010000, 5'd7,  5'd9,  3'b001, 5'd11, OP), mk(E_LT,   5'd9,  5'd7,  5'd11, 1'b1));
    step("fle",   ins(7'b1010000, 5'd3,  5'd27, 3'b000, 5'd25, OP), mk(E_LE,   5'd27, 5'd3,  5'd25, 1'b1));
    step("bad_opcode", ins(7'b0000000, 5'd10, 5'd17, 3'b000, 5'd15, 7'b0110011), 27'd0);
    step("cmp_bad_f3", ins(7'b1010000, 5'd3, 5'd27, 3'b011, 5'd25, OP), 27'd0);
    step("bad_funct7", ins(7'b0000001, 5'd3, 5'd27, 3'b000, 5'd25, OP), 27'd0);
    step("fmax_again", ins(7'b0010100, 5'd31, 5'd30, 3'b001, 5'd29, OP), mk(E_MAX, 5'd30, 5'd31, 5'd29, 1'b1));

    // Asynchronous clear between clock edges, then decode resumes at release edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_now("async_clear", 27'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_reset_fadd", ins(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd31, OP), mk(E_ADD, 5'd2, 5'd1, 5'd31, 1'b1));
    step("zero_instr", 32'h0000_0000, 27'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_decoder.md
Name: fpu_decoder

Overview:
Single-precision floating-point instruction decoder for the RISC-V OP-FP major opcode (1010011). It sits between instruction fetch and the FP ALU. It decodes one 32-bit instruction per clock into one-hot unit enables (add, sub, mul, div, sqrt, max, min, eq, lt, le), register addresses, and register-file read/write strobes. All outputs are registered.

Parameters:
none

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
instruction  input  32  instruction word to decode
Fadd_en  output  1  FADD.S selected
Fsub_en  output  1  FSUB.S selected
Fmul_en  output  1  FMUL.S selected
Fdiv_en  output  1  FDIV.S selected
Fsqrt_en  output  1  FSQRT.S selected
Fmax_en  output  1  FMAX.S selected
Fmin_en  output  1  FMIN.S selected
Feq_en  output  1  FEQ.S selected
Flt_en  output  1  FLT.S selected
Fleq_en  output  1  FLE.S selected
rs1  output  5  source register 1 address
rs2  output  5  source register 2 address
rd  output  5  destination register address
rd_en  output  1  register-file read enable
wr_en  output  1  register-file write enable

Behaviour:
- Field split: funct7=[31:25], rs2f=[24:20], rs1f=[19:15], funct3=[14:12], rdf=[11:7], opcode=[6:0].
- Valid only when opcode==1010011. Any other opcode decodes as invalid.
- funct7 0000000 -> Fadd_en. 0000100 -> Fsub_en. 0001000 -> Fmul_en. 0001100 -> Fdiv_en. funct3 is the rounding mode for these ops and is ignored (any value is accepted).
- funct7 0101100 with rs2f==00000 -> Fsqrt_en. funct3 is ignored. If rs2f is nonzero, the instruction is invalid.
- funct7 0010100: funct3 000 -> Fmin_en; 001 -> Fmax_en; any other funct3 is invalid.
- funct7 1010000: funct3 010 -> Feq_en; 001 -> Flt_en; 000 -> Fleq_en; any other funct3 is invalid.
- Any other funct7 is invalid.
- At most one enable is high in any cycle (one-hot or all-zero).
- Valid decode:
  - rs1=rs1f and rd=rdf.
  - rs2=rs2f, except FSQRT forces rs2=0.
  - rd_en=1 and wr_en=1.
- Invalid decode: all enables 0, rs1=rs2=rd=0, rd_en=0, wr_en=0.
- Latency: purely combinational decode into an output register. Outputs reflect the instruction sampled at a rising edge and hold until the next edge. Latency is 1 cycle and throughput is 1 instruction per cycle. There is no stall or handshake.
- Reset: while rst==0, all outputs are forced to 0 asynchronously, including all enables, rs1, rs2, rd, rd_en and wr_en.
- Reset release: takes effect at the first rising edge with rst==1.
- Reset mid-stream: outputs clear immediately. The instruction presented at the reset-release edge is decoded normally.
- instruction==0 decodes as invalid, so all outputs are 0.

Test Plan:
- Reset: hold rst=0 with an arbitrary instruction -> all outputs 0. Release rst and apply 32'h0 -> all outputs remain 0.
- FADD 0000000_01010_10001_000_01111_1010011 -> next edge: Fadd_en=1 (only enable), rs1=17, rs2=10, rd=15, rd_en=wr_en=1.
- FSUB 0000100_01000_10110_000_00101_1010011 -> Fsub_en=1, rs1=22, rs2=8, rd=5.
- FMUL 0001000_01100_10001_001_11011_1010011 -> Fmul_en=1, rs1=17, rs2=12, rd=27 (rm=001 accepted).
- FSQRT 0101100_00000_10111_001_11001_1010011 -> Fsqrt_en=1, rs1=23, rs2=0, rd=25.
- FSQRT with rs2f=00001 -> all outputs 0.
- Min/max and compares, each checked for one-hot enable and correct addresses:
  - FMAX 0010100_01101_10101_001_10011 -> Fmax_en=1, rs1=21, rs2=13, rd=19.
  - FMIN funct3=000 -> Fmin_en=1.
  - FEQ 1010000_11011_10011_010_01000 -> Feq_en=1, rs1=19, rs2=27, rd=8.
  - FLT funct3=001 -> Flt_en=1.
  - FLE 1010000_00011_11011_000_11001 -> Fleq_en=1, rs1=27, rs2=3, rd=25.
- Illegal cases:
  - opcode 0110011 -> all outputs 0.
  - funct7 1010000 with funct3 011 -> all outputs 0.
  - rst pulled low mid-sequence -> outputs clear without waiting for a clock edge.
